// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO store bridge: register offsets, STATUS bit
// positions and the queued store entry layout.
package mmio_pkg;

    localparam logic [7:0] STATUS_OFS  = 8'h00;
    localparam logic [7:0] CTRL_OFS    = 8'h04;
    localparam logic [7:0] DATA_LO_OFS = 8'h10;

    localparam int STATUS_EMPTY_BIT = 0;
    localparam int STATUS_FULL_BIT  = 1;
    localparam int STATUS_OVF_BIT   = 2;
    localparam int STATUS_COUNT_LSB = 8;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } store_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with occupancy count. Storage is a small flop array
// so that a reset flushes every entry and the head output reads as zero.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic             push, pop;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(DEPTH));
    assign count = count_reg;

    // A write into a full FIFO is still accepted when the head leaves on the same edge.
    assign pop  = rd_en & ~empty;
    assign push = wr_en & (~full | pop);

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) wr_ptr_next = wr_ptr_reg + AW'(1);
        if (pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                mem_reg[gi] <= '0;
            end else if (push && wr_ptr_reg == AW'(gi)) begin
                mem_reg[gi] <= wr_data;
            end
        end
    end

    assign rd_data = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/mmio_store_bridge.sv
// CPU store-port responder: decodes a 256-byte window, queues DATA stores into a
// FIFO drained over valid/ready, and exposes a pollable STATUS word.
module mmio_store_bridge
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
    parameter int          DEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic        hit,
    output logic [31:0] ReadData,
    output logic        per_valid,
    input  logic        per_ready,
    output logic [7:0]  per_addr,
    output logic [31:0] per_data
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]  rel_addr;
    logic [7:0]   offset;
    logic [7:0]   word_ofs;
    logic         is_ctrl, is_data;
    logic         enq_req, deq, drop, ovf_clr;
    logic         overflow_reg, overflow_next;
    logic         fifo_empty, fifo_full;
    logic [CW-1:0] fifo_count;
    logic [31:0]  status;
    store_entry_t wr_entry, head_entry;

    // Unsigned difference keeps the window check correct for any base alignment.
    assign rel_addr = DataAdr - BASE_ADDR;
    assign hit      = (rel_addr[31:8] == 24'd0);
    assign offset   = rel_addr[7:0];
    assign word_ofs = {offset[7:2], 2'b00};
    assign is_ctrl  = hit && (word_ofs == CTRL_OFS);
    assign is_data  = hit && (word_ofs >= DATA_LO_OFS);

    assign enq_req = MemWrite & is_data;
    assign deq     = per_valid & per_ready;
    assign drop    = enq_req & fifo_full & ~deq;
    assign ovf_clr = MemWrite & is_ctrl & WriteData[0];

    always_comb begin
        overflow_next = overflow_reg;
        if (ovf_clr) overflow_next = 1'b0;
        // A drop on the same edge as a clear must leave the flag set.
        if (drop)    overflow_next = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) overflow_reg <= 1'b0;
        else        overflow_reg <= overflow_next;
    end

    assign wr_entry.addr = offset;
    assign wr_entry.data = WriteData;

    sync_fifo #(
        .WIDTH ($bits(store_entry_t)),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (enq_req),
        .wr_data (wr_entry),
        .rd_en   (per_ready),
        .rd_data (head_entry),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    assign per_valid = ~fifo_empty;
    assign per_addr  = head_entry.addr;
    assign per_data  = head_entry.data;

    always_comb begin
        status = '0;
        status[STATUS_EMPTY_BIT] = fifo_empty;
        status[STATUS_FULL_BIT]  = fifo_full;
        status[STATUS_OVF_BIT]   = overflow_reg;
        status[STATUS_COUNT_LSB +: 8] = 8'(fifo_count);
    end

    assign ReadData = (DataAdr == BASE_ADDR) ? status : 32'd0;

endmodule

// File: tb/tb_mmio_store_bridge.sv
// Directed bench for mmio_store_bridge: stimulus pushes expected drained entries
// into a scoreboard queue; a monitor pops and compares on every handshake.
module tb_mmio_store_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = 32'd0;
    logic [31:0] WriteData = 32'd0;
    logic        hit;
    logic [31:0] ReadData;
    logic        per_valid;
    logic        per_ready = 1'b0;
    logic [7:0]  per_addr;
    logic [31:0] per_data;

    int checks = 0;
    int errors = 0;
    logic [39:0] exp_q [$];

    mmio_store_bridge #(
        .BASE_ADDR (32'h0000_0400),
        .DEPTH     (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .hit       (hit),
        .ReadData  (ReadData),
        .per_valid (per_valid),
        .per_ready (per_ready),
        .per_addr  (per_addr),
        .per_data  (per_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end else begin
            $display("ok   %s: %08h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] adr, input logic [31:0] dat);
        MemWrite  = 1'b1;
        DataAdr   = adr;
        WriteData = dat;
        step();
        MemWrite  = 1'b0;
    endtask

    task automatic read_status(input string name, input logic [31:0] exp);
        DataAdr = 32'h0000_0400;
        #1;
        chk(name, ReadData, exp);
    endtask

    // Scoreboard monitor: a handshake seen at the falling edge completes on the next rise.
    initial begin
        logic [39:0] e;
        forever begin
            @(negedge clk);
            if (reset && per_valid && per_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL drain: unexpected entry addr %02h data %08h", per_addr, per_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({per_addr, per_data} !== e) begin
                        errors++;
                        $display("FAIL drain: got addr %02h data %08h expected addr %02h data %08h",
                                 per_addr, per_data, e[39:32], e[31:0]);
                    end else begin
                        $display("ok   drain: addr %02h data %08h", per_addr, per_data);
                    end
                end
            end
        end
    end

    initial begin
        #22;
        reset = 1'b1;
        step();

        // 1. reset state
        chk("reset_valid", {31'd0, per_valid}, 32'd0);
        read_status("reset_status", 32'h0000_0001);

        // 2. single store, one-cycle visibility
        per_ready = 1'b1;
        exp_q.push_back({8'h10, 32'd7});
        store(32'h0000_0410, 32'd7);
        chk("single_valid_hi", {31'd0, per_valid}, 32'd1);
        step();
        chk("single_valid_lo", {31'd0, per_valid}, 32'd0);

        // 3. overfill with the peripheral stalled
        per_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back({8'h20, 32'(i)});
            store(32'h0000_0420, 32'(i));
        end
        read_status("full_ovf_status", 32'h0000_0406);
        chk("head_stable", per_data, 32'd1);

        // 4. store and dequeue on the same edge while full
        per_ready = 1'b1;
        exp_q.push_back({8'h20, 32'd9});
        store(32'h0000_0420, 32'd9);
        per_ready = 1'b0;
        read_status("full_simul_status", 32'h0000_0406);
        per_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        read_status("drained_ovf_status", 32'h0000_0005);

        // 5. CTRL clears overflow, nothing enqueued
        store(32'h0000_0404, 32'd1);
        read_status("ctrl_clear_status", 32'h0000_0001);
        chk("ctrl_no_enq", {31'd0, per_valid}, 32'd0);

        // 6. outside window and reserved offsets
        DataAdr = 32'h0000_0064;
        #1;
        chk("outside_hit", {31'd0, hit}, 32'd0);
        store(32'h0000_0064, 32'd5);
        read_status("outside_status", 32'h0000_0001);
        DataAdr = 32'h0000_0408;
        #1;
        chk("reserved_hit", {31'd0, hit}, 32'd1);
        store(32'h0000_0408, 32'd5);
        read_status("reserved_status", 32'h0000_0001);
        DataAdr = 32'h0000_0410;
        #1;
        chk("nonstatus_read", ReadData, 32'd0);

        // async reset with entries queued
        per_ready = 1'b0;
        store(32'h0000_0410, 32'hA);
        store(32'h0000_0414, 32'hB);
        store(32'h0000_0418, 32'hC);
        read_status("three_queued", 32'h0000_0300);
        #2;
        reset = 1'b0;
        #1;
        chk("reset_drop_valid", {31'd0, per_valid}, 32'd0);
        chk("reset_zero_data", per_data, 32'd0);
        exp_q.delete();
        @(negedge clk);
        #1;
        reset = 1'b1;
        step();
        read_status("post_reset_status", 32'h0000_0001);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
